sort4_seq_ctrl: RTL and testbench



---
 rtl/sort4_seq_ctrl_if.sv | 33 +++
 rtl/sort4_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_sort4_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort4_seq_ctrl_if.sv
// Handshake bundle for sort4_seq_ctrl: upstream valid/ready with the four operands,
// downstream valid/ready with the sorted result and status.
interface sort4_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_d;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic [2:0]       swap_cnt;
    logic             busy;

    // master: the environment around the sorter (producer + consumer)
    modport master (
        output in_valid, in_a, in_b, in_c, in_d, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_c, out_d, swap_cnt, busy
    );

    // slave: the sorter itself
    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, out_ready,
        output in_ready, out_valid, out_a, out_b, out_c, out_d, swap_cnt, busy
    );
endinterface

// File: rtl/sort4_seq_ctrl.sv
// Four-element sorter that walks the 5-pair sorting network through one shared
// compare-exchange unit, one pair per clock, with valid/ready on both sides.
module sort4_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter bit ASCEND = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    sort4_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [3:0][WIDTH-1:0] quad_t;

    localparam logic [2:0] LAST_STEP = 3'd4;

    state_t     state, state_nxt;
    logic [2:0] step, step_nxt;
    quad_t      work, work_nxt;
    quad_t      res, res_nxt;
    logic [2:0] swaps, swaps_nxt;

    logic [1:0]       idx_x, idx_y;
    logic [WIDTH-1:0] op_x, op_y;
    logic             do_swap;
    quad_t            work_xchg;

    // Network schedule: (0,2) (1,3) (0,1) (2,3) (1,2)
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        idx_x = 2'd0;
        idx_y = 2'd2;
        case (step)
            3'd0:    begin idx_x = 2'd0; idx_y = 2'd2; end
            3'd1:    begin idx_x = 2'd1; idx_y = 2'd3; end
            3'd2:    begin idx_x = 2'd0; idx_y = 2'd1; end
            3'd3:    begin idx_x = 2'd2; idx_y = 2'd3; end
            3'd4:    begin idx_x = 2'd1; idx_y = 2'd2; end
            default: begin idx_x = 2'd0; idx_y = 2'd2; end
        endcase
    end

    // Shared compare-exchange unit; strict compare so ties stay in place.
    always_comb begin
        op_x      = work[idx_x];
        op_y      = work[idx_y];
        do_swap   = ASCEND ? (op_x > op_y) : (op_x < op_y);
        work_xchg = work;
        if (do_swap) begin
            work_xchg[idx_x] = op_y;
            work_xchg[idx_y] = op_x;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        work_nxt  = work;
        res_nxt   = res;
        swaps_nxt = swaps;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    work_nxt  = {bus.in_d, bus.in_c, bus.in_b, bus.in_a};
                    swaps_nxt = 3'd0;
                    step_nxt  = 3'd0;
                    state_nxt = S_SORT;
                end
            end
            S_SORT: begin
                work_nxt = work_xchg;
                if (do_swap) begin
                    swaps_nxt = swaps + 3'd1;
                end
                if (step == LAST_STEP) begin
                    res_nxt   = work_xchg;
                    step_nxt  = 3'd0;
                    state_nxt = S_DONE;
                end else begin
                    step_nxt = step + 3'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= 3'd0;
            // NOTE: the working and result registers are reset too, so a partial sort never leaks out.
            work  <= '0;
            res   <= '0;
            swaps <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            step  <= step_nxt;
            work  <= work_nxt;
            res   <= res_nxt;
            swaps <= swaps_nxt;
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_a     = res[0];
    assign bus.out_b     = res[1];
    assign bus.out_c     = res[2];
    assign bus.out_d     = res[3];
    assign bus.swap_cnt  = swaps;

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Self-checking bench for sort4_seq_ctrl: directed table, handshake corner cases,
// and a back-to-back random run against a rank-based reference sort.
module tb_sort4_seq_ctrl;

    localparam int W = 4;

    typedef logic [3:0][W-1:0] quad_t;

    typedef struct {
        string name;
        quad_t din;
        bit    asc;
        quad_t dout;
        int    swaps;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    quad_t got_asc, got_desc;
    int    sw_asc, sw_desc, latency;

    sort4_seq_ctrl_if #(.WIDTH(W)) ifa ();
    sort4_seq_ctrl_if #(.WIDTH(W)) ifd ();

    sort4_seq_ctrl #(.WIDTH(W), .ASCEND(1'b1)) dut_asc (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    sort4_seq_ctrl #(.WIDTH(W), .ASCEND(1'b0)) dut_desc (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic quad_t mk(input int a, input int b, input int c, input int d);
        quad_t q;
        q[0] = W'(a);
        q[1] = W'(b);
        q[2] = W'(c);
        q[3] = W'(d);
        return q;
    endfunction

    // Reference: place each element by its rank (ties broken by position).
    function automatic quad_t ref_sorted(input quad_t v, input bit asc);
        quad_t s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            int rank = 0;
            for (int j = 0; j < 4; j++) begin
                if (asc ? (v[j] < v[i] || (v[j] == v[i] && j < i))
                        : (v[j] > v[i] || (v[j] == v[i] && j < i)))
                    rank++;
            end
            s[rank] = v[i];
        end
        return s;
    endfunction

    function automatic int ref_swaps(input quad_t v, input bit asc);
        int px[5] = '{0, 1, 0, 2, 1};
        int py[5] = '{2, 3, 1, 3, 2};
        int n = 0;
        logic [W-1:0] t;
        for (int k = 0; k < 5; k++) begin
            if (asc ? (v[px[k]] > v[py[k]]) : (v[px[k]] < v[py[k]])) begin
                t        = v[px[k]];
                v[px[k]] = v[py[k]];
                v[py[k]] = t;
                n++;
            end
        end
        return n;
    endfunction

    function automatic quad_t rand_quad();
        quad_t q;
        for (int i = 0; i < 4; i++) q[i] = W'($urandom_range(0, (1 << W) - 1));
        return q;
    endfunction

    task automatic drive(input quad_t q, input logic v);
        ifa.in_a = q[0]; ifa.in_b = q[1]; ifa.in_c = q[2]; ifa.in_d = q[3];
        ifd.in_a = q[0]; ifd.in_b = q[1]; ifd.in_c = q[2]; ifd.in_d = q[3];
        ifa.in_valid = v;
        ifd.in_valid = v;
    endtask

    task automatic set_out_ready(input logic r);
        ifa.out_ready = r;
        ifd.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture();
        got_asc  = {ifa.out_d, ifa.out_c, ifa.out_b, ifa.out_a};
        got_desc = {ifd.out_d, ifd.out_c, ifd.out_b, ifd.out_a};
        sw_asc   = int'(ifa.swap_cnt);
        sw_desc  = int'(ifd.swap_cnt);
    endtask

    // Counts edges after the accepting edge until out_valid shows, bounded.
    task automatic wait_valid();
        latency = 0;
        while (!ifa.out_valid && latency < 20) begin
            tick();
            latency++;
        end
        check("out_valid_seen", ifa.out_valid, 1);
        check("desc_valid_in_step", ifd.out_valid, 1);
    endtask

    // Full transaction with out_ready=1: accept, sort, one DONE cycle, back to IDLE.
    task automatic run_set(input quad_t q);
        int cyc = 0;
        while (!ifa.in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("ready_before_accept", ifa.in_ready, 1);
        drive(q, 1'b1);
        tick();
        drive(q, 1'b0);
        check("busy_in_sort", ifa.busy, 1);
        check("in_ready_in_sort", ifa.in_ready, 0);
        wait_valid();
        check("latency", latency, 5);
        capture();
        tick();
        check("valid_one_cycle", ifa.out_valid, 0);
        check("in_ready_after_done", ifa.in_ready, 1);
    endtask

    vec_t vecs[8];
    quad_t pending[$];

    initial begin
        quad_t held, q;
        int held_sw, results, accepts, last_acc, cyc;

        vecs[0] = '{"sort_9371",   mk(9, 3, 7, 1),   1'b1, mk(1, 3, 7, 9),   5};
        vecs[1] = '{"presorted",   mk(1, 2, 3, 4),   1'b1, mk(1, 2, 3, 4),   0};
        vecs[2] = '{"all_equal",   mk(5, 5, 5, 5),   1'b1, mk(5, 5, 5, 5),   0};
        vecs[3] = '{"boundary",    mk(15, 0, 15, 0), 1'b1, mk(0, 0, 15, 15), 3};
        vecs[4] = '{"desc_9371",   mk(9, 3, 7, 1),   1'b0, mk(9, 7, 3, 1),   1};
        vecs[5] = '{"reverse",     mk(4, 3, 2, 1),   1'b1, mk(1, 2, 3, 4),   4};
        vecs[6] = '{"desc_zeros",  mk(0, 0, 0, 0),   1'b0, mk(0, 0, 0, 0),   0};
        vecs[7] = '{"desc_1234",   mk(1, 2, 3, 4),   1'b0, mk(4, 3, 2, 1),   4};

        drive('0, 1'b0);
        set_out_ready(1'b1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", ifa.in_ready, 1);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_outs", {ifa.out_d, ifa.out_c, ifa.out_b, ifa.out_a}, 0);
        check("rst_swap_cnt", ifa.swap_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            run_set(vecs[i].din);
            check({vecs[i].name, "_out"}, vecs[i].asc ? got_asc : got_desc, vecs[i].dout);
            check({vecs[i].name, "_swaps"}, vecs[i].asc ? sw_asc : sw_desc, vecs[i].swaps);
        end

        // Backpressure: result and status must hold while out_ready=0.
        set_out_ready(1'b0);
        drive(mk(9, 3, 7, 1), 1'b1);
        tick();
        drive(mk(9, 3, 7, 1), 1'b0);
        wait_valid();
        capture();
        held    = got_asc;
        held_sw = sw_asc;
        check("bp_first_out", held, mk(1, 3, 7, 9));
        for (int k = 0; k < 3; k++) begin
            drive(rand_quad(), 1'b1);
            tick();
            check("bp_valid_held", ifa.out_valid, 1);
            check("bp_in_ready_low", ifa.in_ready, 0);
            check("bp_out_held", {ifa.out_d, ifa.out_c, ifa.out_b, ifa.out_a}, held);
            check("bp_swaps_held", ifa.swap_cnt, held_sw);
        end
        drive('0, 1'b0);
        set_out_ready(1'b1);
        tick();
        check("bp_release_valid", ifa.out_valid, 0);
        check("bp_release_ready", ifa.in_ready, 1);
        check("idle_keeps_out", {ifa.out_d, ifa.out_c, ifa.out_b, ifa.out_a}, held);
        check("idle_keeps_swaps", ifa.swap_cnt, 5);

        // Reset while step2 is pending in SORT.
        drive(mk(9, 3, 7, 1), 1'b1);
        tick();
        drive('0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", ifa.out_valid, 0);
        check("midrst_ready", ifa.in_ready, 1);
        check("midrst_busy", ifa.busy, 0);
        check("midrst_outs", {ifa.out_d, ifa.out_c, ifa.out_b, ifa.out_a}, 0);
        check("midrst_swaps", ifa.swap_cnt, 0);
        run_set(mk(4, 3, 2, 1));
        check("post_rst_out", got_asc, mk(1, 2, 3, 4));
        check("post_rst_swaps", sw_asc, 4);

        // Back-to-back: in_valid stays high with fresh data every cycle.
        results  = 0;
        accepts  = 0;
        last_acc = 0;
        cyc      = 0;
        q = rand_quad();
        drive(q, 1'b1);
        while (results < 500 && cyc < 500 * 7 + 100) begin
            if (ifa.out_valid) begin
                quad_t src;
                capture();
                if (pending.size() == 0) begin
                    check("b2b_unexpected_result", 1, 0);
                end else begin
                    src = pending.pop_front();
                    check("b2b_asc_out", got_asc, ref_sorted(src, 1'b1));
                    check("b2b_asc_swaps", sw_asc, ref_swaps(src, 1'b1));
                    check("b2b_desc_out", got_desc, ref_sorted(src, 1'b0));
                    check("b2b_desc_swaps", sw_desc, ref_swaps(src, 1'b0));
                end
                results++;
            end
            if (ifa.in_ready) begin
                if (accepts > 0) check("b2b_accept_gap", cyc - last_acc, 7);
                pending.push_back(q);
                last_acc = cyc;
                accepts++;
            end
            tick();
            cyc++;
            q = rand_quad();
            drive(q, 1'b1);
        end
        drive('0, 1'b0);
        check("b2b_result_count", results, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
